// File: rtl/vga_timing_gen.sv
// Runtime-programmable VGA timing generator: pixel divider, per-axis sync polarity and
// frame-boundary shadowed timing writes. Define VGA_TIMING_LINE_IRQ_EN for the line-compare IRQ.
module vga_timing_gen #(
  parameter int unsigned H_WIDTH         = 12,
  parameter int unsigned V_WIDTH         = 11,
  parameter int unsigned FRAME_CNT_WIDTH = 16,
  parameter int unsigned PIX_DIV_WIDTH   = 2
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
`ifdef VGA_TIMING_LINE_IRQ_EN
  input  logic [V_WIDTH-1:0]         line_cmp_i,
  output logic                       line_irq_o,
`endif
  input  logic [PIX_DIV_WIDTH-1:0]   pix_div_i,
  input  logic                       cfg_we_i,
  input  logic [H_WIDTH-1:0]         hd_i,
  input  logic [H_WIDTH-1:0]         hf_i,
  input  logic [H_WIDTH-1:0]         hr_i,
  input  logic [H_WIDTH-1:0]         hb_i,
  input  logic [V_WIDTH-1:0]         vd_i,
  input  logic [V_WIDTH-1:0]         vf_i,
  input  logic [V_WIDTH-1:0]         vr_i,
  input  logic [V_WIDTH-1:0]         vb_i,
  input  logic                       hs_pol_i,
  input  logic                       vs_pol_i,
  output logic                       cfg_pending_o,
  output logic                       cfg_err_o,
  output logic                       vga_hs_o,
  output logic                       vga_vs_o,
  output logic [H_WIDTH-1:0]         hcount_o,
  output logic [V_WIDTH-1:0]         vcount_o,
  output logic                       pixel_enable_o,
  output logic                       pix_tick_o,
  output logic                       frame_start_o,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt_o
);

  typedef struct packed {
    logic [H_WIDTH-1:0] hd, hf, hr, hb;
    logic [V_WIDTH-1:0] vd, vf, vr, vb;
    logic               hs_pol, vs_pol;
    logic [H_WIDTH:0]   htot;
    logic [V_WIDTH:0]   vtot;
  } timing_t;

  localparam timing_t RstTiming = '{
    hd: H_WIDTH'(640), hf: H_WIDTH'(16), hr: H_WIDTH'(96), hb: H_WIDTH'(48),
    vd: V_WIDTH'(480), vf: V_WIDTH'(10), vr: V_WIDTH'(2),  vb: V_WIDTH'(33),
    hs_pol: 1'b0, vs_pol: 1'b0,
    htot: (H_WIDTH+1)'(800), vtot: (V_WIDTH+1)'(525)
  };

  timing_t                      act_q, shd_q, cfg_new;
  logic                         run_q, pending_q, err_q;
  logic [PIX_DIV_WIDTH-1:0]     div_q;
  logic [H_WIDTH-1:0]           hcount_q;
  logic [V_WIDTH-1:0]           vcount_q;
  logic [FRAME_CNT_WIDTH-1:0]   frame_cnt_q;

  logic                         pix_tick, h_last, v_last, boundary, cfg_ok;
  logic                         h_disp, v_disp, in_hsync, in_vsync;
  logic [H_WIDTH+1:0]           hsum;
  logic [V_WIDTH+1:0]           vsum;
  logic [H_WIDTH:0]             hcnt_x, hs_beg, hs_end;
  logic [V_WIDTH:0]             vcnt_x, vs_beg, vs_end;

  // Sums use two extra bits so four large fields cannot wrap back into the legal range.
  always_comb begin
    hsum    = (H_WIDTH+2)'(hd_i) + (H_WIDTH+2)'(hf_i) + (H_WIDTH+2)'(hr_i) + (H_WIDTH+2)'(hb_i);
    vsum    = (V_WIDTH+2)'(vd_i) + (V_WIDTH+2)'(vf_i) + (V_WIDTH+2)'(vr_i) + (V_WIDTH+2)'(vb_i);
    cfg_ok  = (hd_i != '0) && (hr_i != '0) && (vd_i != '0) && (vr_i != '0) &&
              (hsum[H_WIDTH+1:H_WIDTH] == 2'b00) && (vsum[V_WIDTH+1:V_WIDTH] == 2'b00);
    cfg_new = '{hd: hd_i, hf: hf_i, hr: hr_i, hb: hb_i,
                vd: vd_i, vf: vf_i, vr: vr_i, vb: vb_i,
                hs_pol: hs_pol_i, vs_pol: vs_pol_i,
                htot: hsum[H_WIDTH:0], vtot: vsum[V_WIDTH:0]};
  end

  // run_q holds off the first tick until the clock after reset release.
  always_comb begin
    pix_tick = run_q && (div_q >= pix_div_i);
    hcnt_x   = {1'b0, hcount_q};
    vcnt_x   = {1'b0, vcount_q};
    h_last   = (hcnt_x == act_q.htot - (H_WIDTH+1)'(1));
    v_last   = (vcnt_x == act_q.vtot - (V_WIDTH+1)'(1));
    boundary = pix_tick && h_last && v_last;
    hs_beg   = {1'b0, act_q.hd} + {1'b0, act_q.hf};
    hs_end   = hs_beg + {1'b0, act_q.hr};
    vs_beg   = {1'b0, act_q.vd} + {1'b0, act_q.vf};
    vs_end   = vs_beg + {1'b0, act_q.vr};
    h_disp   = hcount_q < act_q.hd;
    v_disp   = vcount_q < act_q.vd;
    in_hsync = (hcnt_x >= hs_beg) && (hcnt_x < hs_end);
    in_vsync = (vcnt_x >= vs_beg) && (vcnt_x < vs_end);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      run_q       <= 1'b0;
      div_q       <= '0;
      hcount_q    <= '0;
      vcount_q    <= '0;
      frame_cnt_q <= '0;
      act_q       <= RstTiming;
      shd_q       <= RstTiming;
      pending_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (run_q) div_q <= pix_tick ? '0 : div_q + PIX_DIV_WIDTH'(1);
      if (pix_tick) begin
        if (h_last) begin
          hcount_q <= '0;
          vcount_q <= v_last ? '0 : vcount_q + V_WIDTH'(1);
        end else begin
          hcount_q <= hcount_q + H_WIDTH'(1);
        end
      end
      if (boundary) begin
        frame_cnt_q <= frame_cnt_q + FRAME_CNT_WIDTH'(1);
        if (pending_q) begin
          act_q     <= shd_q;
          pending_q <= 1'b0;
        end
      end
      // A write coinciding with an apply lands in the shadow and keeps pending set.
      if (cfg_we_i) begin
        if (cfg_ok) begin
          shd_q     <= cfg_new;
          pending_q <= 1'b1;
          err_q     <= 1'b0;
        end else begin
          err_q     <= 1'b1;
        end
      end
    end
  end

  assign pix_tick_o     = pix_tick;
  assign hcount_o       = hcount_q;
  assign vcount_o       = vcount_q;
  assign frame_cnt_o    = frame_cnt_q;
  assign cfg_pending_o  = pending_q;
  assign cfg_err_o      = err_q;
  assign pixel_enable_o = h_disp && v_disp;
  assign vga_hs_o       = ~(in_hsync ^ act_q.hs_pol);
  assign vga_vs_o       = ~(in_vsync ^ act_q.vs_pol);
  assign frame_start_o  = pix_tick && (hcount_q == '0) && (vcount_q == '0);

`ifdef VGA_TIMING_LINE_IRQ_EN
  assign line_irq_o = pix_tick && (hcount_q == '0) && (vcount_q == line_cmp_i);
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: frame-position reference model plus directed
// literal checks and randomized divider/config traffic.
`timescale 1ns/1ps
module tb_vga_timing_gen;
  localparam int HW = 12;
  localparam int VW = 11;
  localparam int FW = 16;
  localparam int DW = 2;

  logic          clk_i = 1'b0;
  logic          arst_i;
  logic [DW-1:0] pix_div_i;
  logic          cfg_we_i;
  logic [HW-1:0] hd_i, hf_i, hr_i, hb_i;
  logic [VW-1:0] vd_i, vf_i, vr_i, vb_i;
  logic          hs_pol_i, vs_pol_i;
  logic          cfg_pending_o, cfg_err_o, vga_hs_o, vga_vs_o;
  logic [HW-1:0] hcount_o;
  logic [VW-1:0] vcount_o;
  logic          pixel_enable_o, pix_tick_o, frame_start_o;
  logic [FW-1:0] frame_cnt_o;
`ifdef VGA_TIMING_LINE_IRQ_EN
  logic [VW-1:0] line_cmp_i;
  logic          line_irq_o;
`endif

  vga_timing_gen #(.H_WIDTH(HW), .V_WIDTH(VW), .FRAME_CNT_WIDTH(FW), .PIX_DIV_WIDTH(DW)) dut (
    .clk_i(clk_i), .arst_i(arst_i),
`ifdef VGA_TIMING_LINE_IRQ_EN
    .line_cmp_i(line_cmp_i), .line_irq_o(line_irq_o),
`endif
    .pix_div_i(pix_div_i), .cfg_we_i(cfg_we_i),
    .hd_i(hd_i), .hf_i(hf_i), .hr_i(hr_i), .hb_i(hb_i),
    .vd_i(vd_i), .vf_i(vf_i), .vr_i(vr_i), .vb_i(vb_i),
    .hs_pol_i(hs_pol_i), .vs_pol_i(vs_pol_i),
    .cfg_pending_o(cfg_pending_o), .cfg_err_o(cfg_err_o),
    .vga_hs_o(vga_hs_o), .vga_vs_o(vga_vs_o),
    .hcount_o(hcount_o), .vcount_o(vcount_o),
    .pixel_enable_o(pixel_enable_o), .pix_tick_o(pix_tick_o),
    .frame_start_o(frame_start_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Reference model: timing fields {hd,hf,hr,hb,vd,vf,vr,vb,hpol,vpol}; position is the
  // tick index within the frame, from which column/line follow by div/mod.
  int act[10];
  int shd[10];
  int m_div, m_run, m_tif, m_frames, m_pend, m_err;

  function automatic int htot();
    return act[0] + act[1] + act[2] + act[3];
  endfunction
  function automatic int vtot();
    return act[4] + act[5] + act[6] + act[7];
  endfunction
  function automatic bit m_tick();
    return (m_run != 0) && (m_div >= int'(pix_div_i));
  endfunction

  task automatic check(input string nm, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
      if (bad >= 100) begin
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  endtask

  task automatic model_reset();
    act = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0};
    shd = act;
    m_div = 0; m_run = 0; m_tif = 0; m_frames = 0; m_pend = 0; m_err = 0;
  endtask

  task automatic model_adv();
    int ht, vt, hs, vs;
    bit tk, bnd;
    ht = htot(); vt = vtot();
    tk = m_tick();
    bnd = tk && (m_tif == ht * vt - 1);
    if (m_run == 0) m_run = 1;
    else if (tk) m_div = 0;
    else m_div++;
    if (tk) m_tif = bnd ? 0 : m_tif + 1;
    if (bnd) begin
      m_frames = (m_frames + 1) % 65536;
      if (m_pend != 0) begin
        act = shd;
        m_pend = 0;
      end
    end
    if (cfg_we_i) begin
      hs = int'(hd_i) + int'(hf_i) + int'(hr_i) + int'(hb_i);
      vs = int'(vd_i) + int'(vf_i) + int'(vr_i) + int'(vb_i);
      if (hd_i >= 1 && hr_i >= 1 && vd_i >= 1 && vr_i >= 1 && hs < 4096 && vs < 2048) begin
        shd = '{int'(hd_i), int'(hf_i), int'(hr_i), int'(hb_i),
                int'(vd_i), int'(vf_i), int'(vr_i), int'(vb_i), int'(hs_pol_i), int'(vs_pol_i)};
        m_pend = 1;
        m_err = 0;
      end else begin
        m_err = 1;
      end
    end
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      int ht, h, v;
      bit tk, hsyn, vsyn;
      ht = htot();
      h = m_tif % ht;
      v = m_tif / ht;
      tk = m_tick();
      hsyn = (h >= act[0] + act[1]) && (h < act[0] + act[1] + act[2]);
      vsyn = (v >= act[4] + act[5]) && (v < act[4] + act[5] + act[6]);
      check("hcount", hcount_o, h);
      check("vcount", vcount_o, v);
      check("pix_tick", pix_tick_o, tk);
      check("pixel_enable", pixel_enable_o, (h < act[0]) && (v < act[4]));
      check("vga_hs", vga_hs_o, hsyn ? act[8] : 1 - act[8]);
      check("vga_vs", vga_vs_o, vsyn ? act[9] : 1 - act[9]);
      check("frame_start", frame_start_o, tk && (m_tif == 0));
      check("frame_cnt", frame_cnt_o, m_frames);
      check("cfg_pending", cfg_pending_o, m_pend);
      check("cfg_err", cfg_err_o, m_err);
`ifdef VGA_TIMING_LINE_IRQ_EN
      check("line_irq", line_irq_o, tk && (h == 0) && (v == int'(line_cmp_i)));
`endif
    end
  end

  // Inputs for the coming edge must already be set; returns just after the following negedge.
  task automatic tick_clk();
    model_adv();
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic do_write(input int a, b, c, d, e, f, g, k, input bit hp, vp);
    hd_i = HW'(a); hf_i = HW'(b); hr_i = HW'(c); hb_i = HW'(d);
    vd_i = VW'(e); vf_i = VW'(f); vr_i = VW'(g); vb_i = VW'(k);
    hs_pol_i = hp; vs_pol_i = vp;
    cfg_we_i = 1'b1;
    tick_clk();
    cfg_we_i = 1'b0;
  endtask

  task automatic wait_hv(input int h, input int v, input int budget, input string nm);
    int n = 0;
    while (!(int'(hcount_o) == h && int'(vcount_o) == v) && n < budget) begin
      tick_clk();
      n++;
    end
    check(nm, (int'(hcount_o) == h && int'(vcount_o) == v), 1);
  endtask

  task automatic wait_fs(input int budget, output int period);
    int c0 = cyc;
    int n = 0;
    do begin
      tick_clk();
      n++;
    end while (!frame_start_o && n < budget);
    check("frame_start_reached", frame_start_o, 1);
    period = cyc - c0;
  endtask

  initial begin
    int per, cnt, n;
    arst_i = 1'b1; pix_div_i = '0; cfg_we_i = 1'b0;
    hd_i = '0; hf_i = '0; hr_i = '0; hb_i = '0;
    vd_i = '0; vf_i = '0; vr_i = '0; vb_i = '0;
    hs_pol_i = 1'b0; vs_pol_i = 1'b0;
`ifdef VGA_TIMING_LINE_IRQ_EN
    line_cmp_i = VW'(479);
`endif
    #2;
    check("rst_hcount", hcount_o, 0);
    check("rst_vcount", vcount_o, 0);
    check("rst_pixel_enable", pixel_enable_o, 1);
    check("rst_hs", vga_hs_o, 1);
    check("rst_vs", vga_vs_o, 1);
    check("rst_pix_tick", pix_tick_o, 0);
    check("rst_frame_start", frame_start_o, 0);
    check("rst_pending", cfg_pending_o, 0);
    model_reset();
    chk_en = 1'b1;
    @(negedge clk_i);
    #1;
    arst_i = 1'b0;

    // Default 640x480 timing.
    tick_clk();
    check("first_frame_start", frame_start_o, 1);
    n = cyc;
    wait_hv(655, 0, 2000, "reach_h655");
    check("hs_h655", vga_hs_o, 1);
    tick_clk();
    check("hs_h656", vga_hs_o, 0);
    wait_hv(751, 0, 200, "reach_h751");
    check("hs_h751", vga_hs_o, 0);
    tick_clk();
    check("hs_h752", vga_hs_o, 1);
    do_write(0, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    check("err_hd0", cfg_err_o, 1);
    check("pend_after_err", cfg_pending_o, 0);
    do_write(8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b0);
    check("pend_after_write", cfg_pending_o, 1);
    check("err_cleared", cfg_err_o, 0);
    do_write(8, 1, 0, 1, 4, 1, 1, 1, 1'b1, 1'b0);
    check("err_hr0", cfg_err_o, 1);
    check("pend_kept", cfg_pending_o, 1);
    do_write(8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b0);
    check("err_cleared2", cfg_err_o, 0);
    wait_hv(0, 490, 400000, "reach_v490");
    check("vs_v490", vga_vs_o, 0);
    wait_hv(0, 492, 2000, "reach_v492");
    check("vs_v492", vga_vs_o, 1);
    wait_fs(30000, per);
    check("default_period", cyc - n, 420000);
    check("frame_cnt_1", frame_cnt_o, 1);
    check("pend_applied", cfg_pending_o, 0);

    // Timing 8/1/2/1 x 4/1/1/1, hsync active-high.
    cnt = 0; n = 0;
    do begin
      if (pix_tick_o && pixel_enable_o) cnt++;
      tick_clk();
      n++;
    end while (!frame_start_o && n < 500);
    check("small_period", n, 84);
    check("pe_per_frame", cnt, 32);
    wait_hv(9, 0, 100, "reach_h9");
    check("hs_pos_h9", vga_hs_o, 1);
    tick_clk(); tick_clk();
    check("hs_pos_h11", vga_hs_o, 0);
`ifdef VGA_TIMING_LINE_IRQ_EN
    line_cmp_i = VW'(5);
    wait_fs(200, per);
    cnt = 0;
    repeat (84) begin
      if (line_irq_o) cnt++;
      tick_clk();
    end
    check("line_irq_once", cnt, 1);
    line_cmp_i = VW'(9);
    cnt = 0;
    repeat (84) begin
      if (line_irq_o) cnt++;
      tick_clk();
    end
    check("line_irq_never", cnt, 0);
`endif

    // Divider /4.
    pix_div_i = DW'(3);
    cnt = 0;
    repeat (40) begin
      tick_clk();
      if (pix_tick_o) cnt++;
    end
    check("div4_ticks", cnt, 10);
    wait_fs(1000, per);
    wait_fs(1000, per);
    check("div4_period", per, 336);

    // Write landing on the boundary tick while another is pending.
    pix_div_i = '0;
    tick_clk();
    do_write(5, 0, 1, 0, 2, 0, 1, 0, 1'b0, 1'b1);
    n = 0;
    while (!(m_tick() && m_tif == htot() * vtot() - 1) && n < 500) begin
      tick_clk();
      n++;
    end
    do_write(3, 1, 1, 1, 2, 1, 1, 0, 1'b1, 1'b1);
    check("bnd_frame_start", frame_start_o, 1);
    check("bnd_pend_kept", cfg_pending_o, 1);
    wait_fs(500, per);
    check("first_write_period", per, 18);
    wait_fs(500, per);
    check("second_write_period", per, 24);
    check("bnd_pend_clear", cfg_pending_o, 0);

    // Randomized divider changes and config writes.
    repeat (15000) begin
      if ($urandom_range(0, 63) == 0) pix_div_i = DW'($urandom_range(0, 3));
`ifdef VGA_TIMING_LINE_IRQ_EN
      if ($urandom_range(0, 31) == 0) line_cmp_i = VW'($urandom_range(0, 15));
`endif
      if ($urandom_range(0, 199) == 0) begin
        case ($urandom_range(0, 7))
          0: do_write(4095, $urandom_range(0, 3), $urandom_range(1, 3), 0,
                      $urandom_range(1, 3), 0, 1, 0, 1'($urandom), 1'($urandom));
          1: do_write($urandom_range(1, 5), 0, $urandom_range(1, 3), 0,
                      2047, 0, $urandom_range(1, 3), 0, 1'($urandom), 1'($urandom));
          default: do_write($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3),
                            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                            $urandom_range(0, 3), $urandom_range(0, 3),
                            1'($urandom), 1'($urandom));
        endcase
      end else begin
        tick_clk();
      end
    end

    // Asynchronous reset mid-frame with a write pending.
    pix_div_i = DW'(1);
    do_write(6, 1, 1, 1, 3, 0, 1, 1, 1'b1, 1'b0);
    repeat (7) tick_clk();
    arst_i = 1'b1;
    #1;
    check("mid_rst_hcount", hcount_o, 0);
    check("mid_rst_vcount", vcount_o, 0);
    check("mid_rst_frame_cnt", frame_cnt_o, 0);
    check("mid_rst_pending", cfg_pending_o, 0);
    check("mid_rst_err", cfg_err_o, 0);
    check("mid_rst_pix_tick", pix_tick_o, 0);
    check("mid_rst_hs", vga_hs_o, 1);
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    arst_i = 1'b0;
    repeat (200) tick_clk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
